// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Bundles the decode, writeback and flush signals that the
//               pipeline presents to the register scoreboard, plus the
//               scoreboard's stall, busy and error outputs.
//               master : pipeline side (drives decode, WB and flush)
//               slave  : scoreboard side
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;
    // Decode / issue side
    logic        ds_valid;
    logic        ds_src1_used;
    logic [4:0]  ds_src1;
    logic        ds_src2_used;
    logic [4:0]  ds_src2;
    logic        ds_gr_we;
    logic [4:0]  ds_dest;
    logic        issue_fire;
    // Writeback / retire side
    logic        ws_valid;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    // Pipeline kill
    logic        flush;
    // Scoreboard outputs
    logic        ds_stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    modport master (
        output ds_valid, ds_src1_used, ds_src1, ds_src2_used, ds_src2,
               ds_gr_we, ds_dest, issue_fire, ws_valid, ws_gr_we, ws_dest,
               flush,
        input  ds_stall, busy_vec, sb_err
    );

    modport slave (
        input  ds_valid, ds_src1_used, ds_src1, ds_src2_used, ds_src2,
               ds_gr_we, ds_dest, issue_fire, ws_valid, ws_gr_we, ws_dest,
               flush,
        output ds_stall, busy_vec, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write scoreboard for the in-order
//               pipeline. Counts writes issued from decode and retired from
//               writeback, and stalls decode on a read of a busy register or
//               a write to a register whose counter is saturated.
// Ports       : clk    - clock
//               reset  - synchronous, active-high reset
//               sb_if  - reg_scoreboard_if.slave (decode, WB, flush inputs;
//                        ds_stall, busy_vec, sb_err outputs)
// Options     : SB_ERR_CHECK_EN - when defined, sb_err latches on counter
//               overflow/underflow attempts; otherwise sb_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    reg_scoreboard_if.slave  sb_if
);

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_zero = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry 0 exists only to keep indexing simple; it is held at zero.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    logic        w_issue_inc;
    logic        w_retire_dec;
    logic [31:0] w_busy;
    logic        w_raw1;
    logic        w_raw2;
    logic        w_full;

    assign w_issue_inc  = sb_if.issue_fire & sb_if.ds_gr_we & (sb_if.ds_dest != 5'd0);
    assign w_retire_dec = sb_if.ws_valid & sb_if.ws_gr_we & (sb_if.ws_dest != 5'd0);

    // Counter next state. Flush discards any same-cycle inc/dec. A register
    // hit by both an issue and a retire in the same cycle keeps its count.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = c_cnt_zero;
        if (sb_if.flush) begin
            for (int r = 1; r < 32; r++) begin
                cnt_d[r] = c_cnt_zero;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_issue_inc && (sb_if.ds_dest == 5'(r)) &&
                    !(w_retire_dec && (sb_if.ws_dest == 5'(r)))) begin
                    if (cnt_q[r] != c_cnt_max) begin
                        cnt_d[r] = cnt_q[r] + c_cnt_one;
                    end
                end else if (w_retire_dec && (sb_if.ws_dest == 5'(r)) &&
                             !(w_issue_inc && (sb_if.ds_dest == 5'(r)))) begin
                    if (cnt_q[r] != c_cnt_zero) begin
                        cnt_d[r] = cnt_q[r] - c_cnt_one;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= c_cnt_zero;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign w_busy[0] = 1'b0;
    for (genvar i = 1; i < 32; i++) begin : g_busy
        assign w_busy[i] = (cnt_q[i] != c_cnt_zero);
    end

    // Stall looks only at registered counters, so a retire in this cycle
    // releases a dependent instruction one cycle later.
    assign w_raw1 = sb_if.ds_src1_used & (sb_if.ds_src1 != 5'd0) & w_busy[sb_if.ds_src1];
    assign w_raw2 = sb_if.ds_src2_used & (sb_if.ds_src2 != 5'd0) & w_busy[sb_if.ds_src2];
    assign w_full = sb_if.ds_gr_we & (sb_if.ds_dest != 5'd0) & (cnt_q[sb_if.ds_dest] == c_cnt_max);

    assign sb_if.ds_stall = sb_if.ds_valid & (w_raw1 | w_raw2 | w_full);
    assign sb_if.busy_vec = w_busy;

`ifdef SB_ERR_CHECK_EN
    logic w_same_reg;
    logic w_err_ovf;
    logic w_err_unf;
    logic sb_err_q;

    // Only a lone inc at max or a lone dec at zero is an error; a paired
    // inc/dec on the same register is a legal no-op.
    assign w_same_reg = w_issue_inc & w_retire_dec & (sb_if.ds_dest == sb_if.ws_dest);
    assign w_err_ovf  = w_issue_inc & ~w_same_reg & (cnt_q[sb_if.ds_dest] == c_cnt_max);
    assign w_err_unf  = w_retire_dec & ~w_same_reg & (cnt_q[sb_if.ws_dest] == c_cnt_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else if (!sb_if.flush && (w_err_ovf || w_err_unf)) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_if.sb_err = sb_err_q;
`else
    assign sb_if.sb_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

`ifdef SB_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sb_if (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.ds_valid     = 1'b0;
        sb_if.ds_src1_used = 1'b0;
        sb_if.ds_src1      = 5'd0;
        sb_if.ds_src2_used = 1'b0;
        sb_if.ds_src2      = 5'd0;
        sb_if.ds_gr_we     = 1'b0;
        sb_if.ds_dest      = 5'd0;
        sb_if.issue_fire   = 1'b0;
        sb_if.ws_valid     = 1'b0;
        sb_if.ws_gr_we     = 1'b0;
        sb_if.ws_dest      = 5'd0;
        sb_if.flush        = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] dest, input logic fire);
        sb_if.ds_valid   = 1'b1;
        sb_if.ds_gr_we   = 1'b1;
        sb_if.ds_dest    = dest;
        sb_if.issue_fire = fire;
    endtask

    task automatic set_retire(input logic [4:0] dest);
        sb_if.ws_valid = 1'b1;
        sb_if.ws_gr_we = 1'b1;
        sb_if.ws_dest  = dest;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0) begin
            errors++; $display("FAIL reset_busy: got %h expected %h", sb_if.busy_vec, 32'h0);
        end
        checks++;
        if (sb_if.ds_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", sb_if.ds_stall);
        end
        checks++;
        if (sb_if.sb_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", sb_if.sb_err);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_stall [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) begin
                set_issue(5'd5, 1'b1);
            end else begin
                sb_if.ds_valid     = 1'b1;
                sb_if.ds_src1_used = 1'b1;
                sb_if.ds_src1      = 5'd5;
                sb_if.issue_fire   = (c == 4);
            end
            if (c == 3) set_retire(5'd5);
            #1;
            checks++;
            if (sb_if.ds_stall !== exp_stall[c]) begin
                errors++;
                $display("FAIL b2b_stall cycle %0d: got %b expected %b", c, sb_if.ds_stall, exp_stall[c]);
            end
            if (c == 4) begin
                checks++;
                if (sb_if.busy_vec[5] !== 1'b0) begin
                    errors++; $display("FAIL b2b_busy5: got %b expected 0", sb_if.busy_vec[5]);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_r0();
        for (int c = 0; c < 4; c++) begin
            idle();
            set_issue(5'd0, 1'b1);
            sb_if.ds_src1_used = 1'b1;
            sb_if.ds_src2_used = 1'b1;
            set_retire(5'd0);
            #1;
            checks++;
            if (sb_if.busy_vec !== 32'h0 || sb_if.ds_stall !== 1'b0) begin
                errors++;
                $display("FAIL r0_immune cycle %0d: busy %h stall %b expected busy 0 stall 0",
                         c, sb_if.busy_vec, sb_if.ds_stall);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0 || sb_if.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL r0_after: busy %h err %b expected busy 0 err 0", sb_if.busy_vec, sb_if.sb_err);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        set_issue(5'd9, 1'b1);
        tick();
        idle();
        set_issue(5'd9, 1'b1);
        set_retire(5'd9);
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL simul_busy: got %h expected %h", sb_if.busy_vec, 32'h0000_0200);
        end
        set_retire(5'd9);
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0 || sb_if.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: busy %h err %b expected busy 0 err 0", sb_if.busy_vec, sb_if.sb_err);
        end
    endtask

    task automatic test_flush();
        idle();
        set_issue(5'd3, 1'b1);
        tick();
        set_issue(5'd4, 1'b1);
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0000_0018) begin
            errors++; $display("FAIL flush_pre: got %h expected %h", sb_if.busy_vec, 32'h0000_0018);
        end
        set_issue(5'd6, 1'b1);
        set_retire(5'd3);
        sb_if.flush = 1'b1;
        tick();
        idle();
        sb_if.ds_valid     = 1'b1;
        sb_if.ds_src1_used = 1'b1;
        sb_if.ds_src1      = 5'd3;
        sb_if.ds_src2_used = 1'b1;
        sb_if.ds_src2      = 5'd4;
        sb_if.ds_gr_we     = 1'b1;
        sb_if.ds_dest      = 5'd6;
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0 || sb_if.ds_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: busy %h stall %b expected busy 0 stall 0",
                     sb_if.busy_vec, sb_if.ds_stall);
        end
        idle();
    endtask

    task automatic test_saturation();
        logic exp_busy [3] = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            idle();
            set_issue(5'd7, 1'b1);
            #1;
            checks++;
            if (sb_if.ds_stall !== 1'b0) begin
                errors++; $display("FAIL sat_issue%0d_stall: got %b expected 0", c, sb_if.ds_stall);
            end
            tick();
        end
        idle();
        set_issue(5'd7, 1'b0);
        #1;
        checks++;
        if (sb_if.ds_stall !== 1'b1 || sb_if.busy_vec[7] !== 1'b1) begin
            errors++;
            $display("FAIL sat_full: stall %b busy7 %b expected stall 1 busy7 1",
                     sb_if.ds_stall, sb_if.busy_vec[7]);
        end
        checks++;
        if (sb_if.sb_err !== 1'b0) begin
            errors++; $display("FAIL sat_err_pre: got %b expected 0", sb_if.sb_err);
        end
        sb_if.issue_fire = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.sb_err !== EXP_ERR) begin
            errors++; $display("FAIL sat_err: got %b expected %b", sb_if.sb_err, EXP_ERR);
        end
        // Count must still be 3: two retires leave it busy, the third clears it.
        for (int c = 0; c < 3; c++) begin
            idle();
            set_retire(5'd7);
            tick();
            idle();
            #1;
            checks++;
            if (sb_if.busy_vec[7] !== exp_busy[c]) begin
                errors++;
                $display("FAIL sat_drain%0d: got %b expected %b", c, sb_if.busy_vec[7], exp_busy[c]);
            end
        end
        sb_if.flush = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.sb_err !== EXP_ERR) begin
            errors++; $display("FAIL sat_err_sticky: got %b expected %b", sb_if.sb_err, EXP_ERR);
        end
    endtask

    task automatic test_underflow();
        idle();
        set_retire(5'd12);
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec !== 32'h0) begin
            errors++; $display("FAIL unf_busy: got %h expected %h", sb_if.busy_vec, 32'h0);
        end
        checks++;
        if (sb_if.sb_err !== EXP_ERR) begin
            errors++; $display("FAIL unf_err: got %b expected %b", sb_if.sb_err, EXP_ERR);
        end
        // A wrapped counter would remain busy after one issue plus one retire.
        set_issue(5'd12, 1'b1);
        tick();
        idle();
        set_retire(5'd12);
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.busy_vec[12] !== 1'b0) begin
            errors++; $display("FAIL unf_nowrap: got %b expected 0", sb_if.busy_vec[12]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_r0();
        test_simultaneous();
        test_flush();
        test_saturation();
        test_reset();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
